// File: rtl/conv_index_sequencer_pkg.sv
// Shared constants and helpers for the convolution index sequencer:
// FSM state encodings, width/limit helpers and integer clamp functions.
package conv_index_sequencer_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Index width; at least one bit even for length-1 vectors.
    function automatic int idx_w(input int x, input int h);
        return imax(1, $clog2(imax(x, h)));
    endfunction

    // Width of n, wide enough for 0..x+h-2 plus out-of-range requests.
    function automatic int n_w(input int x, input int h);
        return imax(1, $clog2(x + h - 1));
    endfunction

    function automatic int n_max(input int x, input int h);
        return x + h - 2;
    endfunction

endpackage

// File: rtl/conv_index_sequencer_if.sv
// Pair stream from the sequencer to the address mux / MAC.
// master drives valid + pair fields, slave drives ready.
interface conv_index_sequencer_if
    import conv_index_sequencer_pkg::*;
#(
    parameter int IDX_W = idx_w(8, 8),
    parameter int N_W   = n_w(8, 8)
);
    logic             pair_valid;
    logic             pair_ready;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    logic [N_W-1:0]   out_n;
    logic             first_term;
    logic             last_term;

    modport master (
        output pair_valid, idx_a, idx_b, out_n,
        output first_term, last_term,
        input  pair_ready
    );

    modport slave (
        input  pair_valid, idx_a, idx_b, out_n,
        input  first_term, last_term,
        output pair_ready
    );
endinterface

// File: rtl/conv_index_sequencer_bounds.sv
// Combinational window for output index n: a_lo, a_hi and b at a_lo.
// Ports: n in; a_lo, a_hi, b_start out (all clamped, IDX_W bits).
module conv_index_sequencer_bounds
    import conv_index_sequencer_pkg::*;
#(
    parameter int X_LEN = 8,
    parameter int H_LEN = 8,
    parameter int IDX_W = idx_w(X_LEN, H_LEN),
    parameter int N_W   = n_w(X_LEN, H_LEN)
) (
    input  logic [N_W-1:0]   n,
    output logic [IDX_W-1:0] a_lo,
    output logic [IDX_W-1:0] a_hi,
    output logic [IDX_W-1:0] b_start
);
    // One extra signed bit so n-(H_LEN-1) can go negative before clamping.
    localparam int SW = N_W + 1;
    localparam logic signed [SW-1:0] H_TOP = SW'(H_LEN - 1);
    localparam logic signed [SW-1:0] X_TOP = SW'(X_LEN - 1);

    logic signed [SW-1:0] n_s;
    logic signed [SW-1:0] lo_raw;
    logic signed [SW-1:0] lo_s;
    logic signed [SW-1:0] hi_s;
    logic signed [SW-1:0] b_s;
    logic                 unused_bits;

    always_comb begin
        n_s    = signed'({1'b0, n});
        lo_raw = n_s - H_TOP;
        lo_s   = lo_raw[SW-1] ? '0 : lo_raw;
        hi_s   = (n_s > X_TOP) ? X_TOP : n_s;
        b_s    = n_s - lo_s;
    end

    assign a_lo    = lo_s[IDX_W-1:0];
    assign a_hi    = hi_s[IDX_W-1:0];
    assign b_start = b_s[IDX_W-1:0];

    // Upper bits are always zero after clamping.
    assign unused_bits = ^{lo_s[SW-1:IDX_W],
                           hi_s[SW-1:IDX_W],
                           b_s[SW-1:IDX_W]};

endmodule

// File: rtl/conv_index_sequencer.sv
// Emits (a,b) index pairs with a+b=n for y[n]=sum x[a]*h[b], single n or sweep.
// Ports: clk, rst_n, start/mode/n_in job request, busy/done/err status, pair stream.
module conv_index_sequencer
    import conv_index_sequencer_pkg::*;
#(
    parameter int X_LEN = 8,
    parameter int H_LEN = 8,
    parameter int IDX_W = idx_w(X_LEN, H_LEN),
    parameter int N_W   = n_w(X_LEN, H_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [N_W-1:0]        n_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    conv_index_sequencer_if.master pair
);
    localparam logic [N_W-1:0] N_MAX = N_W'(n_max(X_LEN, H_LEN));

    logic [1:0]       state;
    logic             mode_q;
    logic [N_W-1:0]   n_q;
    logic [IDX_W-1:0] a_q;
    logic [IDX_W-1:0] b_q;
    logic [IDX_W-1:0] a_hi_q;
    logic             valid_q;
    logic             first_q;
    logic             last_q;

    logic [IDX_W-1:0] a_lo;
    logic [IDX_W-1:0] a_hi;
    logic [IDX_W-1:0] b_start;

    conv_index_sequencer_bounds #(
        .X_LEN (X_LEN),
        .H_LEN (H_LEN),
        .IDX_W (IDX_W),
        .N_W   (N_W)
    ) u_bounds (
        .n       (n_q),
        .a_lo    (a_lo),
        .a_hi    (a_hi),
        .b_start (b_start)
    );

    assign pair.pair_valid = valid_q;
    assign pair.idx_a      = a_q;
    assign pair.idx_b      = b_q;
    assign pair.out_n      = n_q;
    assign pair.first_term = first_q;
    assign pair.last_term  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mode_q  <= 1'b0;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_hi_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!mode && (n_in > N_MAX)) begin
                            err <= 1'b1;
                        end else begin
                            mode_q <= mode;
                            n_q    <= mode ? '0 : n_in;
                            busy   <= 1'b1;
                            state  <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    a_q     <= a_lo;
                    b_q     <= b_start;
                    a_hi_q  <= a_hi;
                    valid_q <= 1'b1;
                    first_q <= 1'b1;
                    last_q  <= (a_lo == a_hi);
                    state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (pair.pair_ready) begin
                        if (a_q != a_hi_q) begin
                            // Next pair of the same n, no bubble.
                            a_q     <= a_q + IDX_W'(1);
                            b_q     <= b_q - IDX_W'(1);
                            first_q <= 1'b0;
                            last_q  <= ((a_q + IDX_W'(1)) == a_hi_q);
                        end else begin
                            valid_q <= 1'b0;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (mode_q && (n_q != N_MAX)) begin
                                n_q   <= n_q + N_W'(1);
                                state <= S_SETUP;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_index_sequencer.sv
// Directed bench for conv_index_sequencer: an 8x8 instance and an 8x3 instance.
// Ports: none; drives both DUTs and checks pairs, flags, status pulses.
module tb_conv_index_sequencer;
    import conv_index_sequencer_pkg::*;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] n;
        logic       f;
        logic       l;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 0, mode8 = 0, rdy8 = 0;
    logic [3:0] n_in8 = 0;
    logic       busy8, done8, err8;
    logic       start3 = 0, mode3 = 0, rdy3 = 0;
    logic [3:0] n_in3 = 0;
    logic       busy3, done3, err3;

    conv_index_sequencer_if #(.IDX_W(3), .N_W(4)) bus8 ();
    conv_index_sequencer_if #(.IDX_W(3), .N_W(4)) bus3 ();

    assign bus8.pair_ready = rdy8;
    assign bus3.pair_ready = rdy3;

    conv_index_sequencer #(.X_LEN(8), .H_LEN(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .mode  (mode8),
        .n_in  (n_in8),
        .busy  (busy8),
        .done  (done8),
        .err   (err8),
        .pair  (bus8.master)
    );

    conv_index_sequencer #(.X_LEN(8), .H_LEN(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .mode  (mode3),
        .n_in  (n_in3),
        .busy  (busy3),
        .done  (done3),
        .err   (err3),
        .pair  (bus3.master)
    );

    always #5 clk = ~clk;

    pair_t p8, p3;
    assign p8 = {bus8.idx_a, bus8.idx_b, bus8.out_n,
                 bus8.first_term, bus8.last_term};
    assign p3 = {bus3.idx_a, bus3.idx_b, bus3.out_n,
                 bus3.first_term, bus3.last_term};

    pair_t q8[$];
    pair_t q3[$];
    int    done_cnt8, err_cnt8, vcnt8, hold_err8, stall_cnt8;
    int    done_cnt3, err_cnt3, vcnt3;
    bit    hold8;
    pair_t snap8;

    // Observe streams mid-cycle; a valid&ready seen here transfers next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold8 = 1'b0;
        end else begin
            if (hold8 && (!bus8.pair_valid || p8 !== snap8))
                hold_err8++;
            hold8 = bus8.pair_valid && !rdy8;
            snap8 = p8;
            if (bus8.pair_valid && !rdy8) stall_cnt8++;
            if (bus8.pair_valid && rdy8) q8.push_back(p8);
            if (bus8.pair_valid) vcnt8++;
            if (done8) done_cnt8++;
            if (err8) err_cnt8++;
            if (bus3.pair_valid && rdy3) q3.push_back(p3);
            if (bus3.pair_valid) vcnt3++;
            if (done3) done_cnt3++;
            if (err3) err_cnt3++;
        end
    end

    int    checks = 0;
    int    errors = 0;
    pair_t got[$];
    pair_t exp_q[$];
    int    jd, je, jv;

    // Expected pairs by brute-force scan of all a with b in range.
    task automatic build_exp(input int x, input int h,
                             input int n0, input int n1);
        exp_q.delete();
        for (int n = n0; n <= n1; n++) begin
            bit first = 1'b1;
            for (int a = 0; a < x; a++) begin
                int b = n - a;
                if (b >= 0 && b < h) begin
                    exp_q.push_back({3'(a), 3'(b), 4'(n), first, 1'b0});
                    first = 1'b0;
                end
            end
            exp_q[exp_q.size()-1].l = 1'b1;
        end
    endtask

    function automatic int first_diff();
        int m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Starts a job at posedge+1 and returns at posedge+1 after completion.
    task automatic run_job(input bit sel, input logic m,
                           input logic [3:0] n, input int budget);
        int qb, db, eb, vb;
        bit seen = 1'b0;
        qb = sel ? q3.size() : q8.size();
        db = sel ? done_cnt3 : done_cnt8;
        eb = sel ? err_cnt3 : err_cnt8;
        vb = sel ? vcnt3 : vcnt8;
        if (sel) begin
            start3 = 1; mode3 = m; n_in3 = n;
        end else begin
            start8 = 1; mode8 = m; n_in8 = n;
        end
        @(posedge clk); #1;
        start3 = 0;
        start8 = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (sel ? (done3 || err3) : (done8 || err8)) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL job_timeout sel=%0d n=%0d: no done/err in %0d cycles",
                     sel, n, budget);
        end
        repeat (2) begin @(posedge clk); #1; end
        got.delete();
        if (sel) for (int i = qb; i < q3.size(); i++) got.push_back(q3[i]);
        else     for (int i = qb; i < q8.size(); i++) got.push_back(q8[i]);
        jd = (sel ? done_cnt3 : done_cnt8) - db;
        je = (sel ? err_cnt3 : err_cnt8) - eb;
        jv = (sel ? vcnt3 : vcnt8) - vb;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if ({busy8, done8, err8, bus8.pair_valid, p8} !== '0) begin
            errors++;
            $display("FAIL reset_out8: got %h want 0",
                     {busy8, done8, err8, bus8.pair_valid, p8});
        end
        checks++;
        if ({busy3, done3, err3, bus3.pair_valid, p3} !== '0) begin
            errors++;
            $display("FAIL reset_out3: got %h want 0",
                     {busy3, done3, err3, bus3.pair_valid, p3});
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_n0();
        rdy8 = 1; start8 = 1; mode8 = 0; n_in8 = 0;
        @(posedge clk); #1;
        start8 = 0;
        checks++;
        if ({busy8, bus8.pair_valid} !== 2'b10) begin
            errors++;
            $display("FAIL n0_setup busy/valid: got %b want 10",
                     {busy8, bus8.pair_valid});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus8.pair_valid, p8} !== {1'b1, 3'd0, 3'd0, 4'd0, 2'b11}) begin
            errors++;
            $display("FAIL n0_pair: got %h want %h", {bus8.pair_valid, p8},
                     {1'b1, 3'd0, 3'd0, 4'd0, 2'b11});
        end
        @(posedge clk); #1;
        checks++;
        if ({done8, busy8, bus8.pair_valid} !== 3'b100) begin
            errors++;
            $display("FAIL n0_done done/busy/valid: got %b want 100",
                     {done8, busy8, bus8.pair_valid});
        end
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL n0_done_pulse: got %b want 0", done8);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_n7(input string tag);
        int d;
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            exp_q.push_back({3'(i), 3'(7 - i), 4'd7, i == 0, i == 7});
        d = first_diff();
        checks++;
        if (got.size() != 8 || d != -1) begin
            errors++;
            $display("FAIL %s_seq: got %0d pairs diff@%0d want 8 pairs diff@-1",
                     tag, got.size(), d);
        end
        checks++;
        if (jd != 1 || je != 0) begin
            errors++;
            $display("FAIL %s_status: got done=%0d err=%0d want 1 0",
                     tag, jd, je);
        end
    endtask

    task automatic test_single_n7();
        rdy8 = 1;
        run_job(0, 0, 4'd7, 50);
        check_n7("n7");
    endtask

    task automatic test_limits();
        rdy8 = 1;
        run_job(0, 0, 4'd14, 50);
        checks++;
        if (got.size() != 1 || got[0] !== {3'd7, 3'd7, 4'd14, 2'b11}) begin
            errors++;
            $display("FAIL n14_pair: got %0d pairs first %h want 1 pair %h",
                     got.size(), got.size() ? got[0] : '0,
                     {3'd7, 3'd7, 4'd14, 2'b11});
        end
        run_job(0, 0, 4'd15, 20);
        checks++;
        if (je != 1 || jd != 0 || jv != 0) begin
            errors++;
            $display("FAIL n15_err: got err=%0d done=%0d valid=%0d want 1 0 0",
                     je, jd, jv);
        end
    endtask

    task automatic test_sweep();
        int d, nf, nl;
        rdy8 = 1;
        run_job(0, 1, 4'd0, 500);
        build_exp(8, 8, 0, 14);
        d = first_diff();
        checks++;
        if (got.size() != 64 || d != -1) begin
            errors++;
            $display("FAIL sweep_seq: got %0d pairs diff@%0d want 64 diff@-1",
                     got.size(), d);
        end
        nf = 0; nl = 0;
        foreach (got[i]) begin
            nf += int'(got[i].f);
            nl += int'(got[i].l);
        end
        checks++;
        if (nf != 15 || nl != 15) begin
            errors++;
            $display("FAIL sweep_flags: got first=%0d last=%0d want 15 15",
                     nf, nl);
        end
        checks++;
        if (jd != 1 || jv != 64) begin
            errors++;
            $display("FAIL sweep_status: got done=%0d valid=%0d want 1 64",
                     jd, jv);
        end
    endtask

    task automatic test_asym();
        int d;
        rdy3 = 1;
        run_job(1, 0, 4'd5, 50);
        exp_q.delete();
        exp_q.push_back({3'd3, 3'd2, 4'd5, 2'b10});
        exp_q.push_back({3'd4, 3'd1, 4'd5, 2'b00});
        exp_q.push_back({3'd5, 3'd0, 4'd5, 2'b01});
        d = first_diff();
        checks++;
        if (got.size() != 3 || d != -1 || jd != 1) begin
            errors++;
            $display("FAIL asym_n5: got %0d pairs diff@%0d done=%0d want 3 -1 1",
                     got.size(), d, jd);
        end
        run_job(1, 0, 4'd9, 50);
        checks++;
        if (got.size() != 1 || got[0] !== {3'd7, 3'd2, 4'd9, 2'b11}) begin
            errors++;
            $display("FAIL asym_n9: got %0d pairs first %h want 1 pair %h",
                     got.size(), got.size() ? got[0] : '0,
                     {3'd7, 3'd2, 4'd9, 2'b11});
        end
        run_job(1, 0, 4'd10, 20);
        checks++;
        if (je != 1 || jd != 0 || jv != 0) begin
            errors++;
            $display("FAIL asym_n10_err: got err=%0d done=%0d valid=%0d want 1 0 0",
                     je, jd, jv);
        end
        run_job(1, 1, 4'd0, 300);
        build_exp(8, 3, 0, 9);
        d = first_diff();
        checks++;
        if (got.size() != 24 || d != -1 || jd != 1) begin
            errors++;
            $display("FAIL asym_sweep: got %0d pairs diff@%0d done=%0d want 24 -1 1",
                     got.size(), d, jd);
        end
    endtask

    task automatic test_stall();
        int qb, hb, db, sb, d;
        bit seen = 1'b0;
        qb = q8.size(); hb = hold_err8; db = done_cnt8; sb = stall_cnt8;
        start8 = 1; mode8 = 1; rdy8 = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start8 = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            rdy8 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (done8) seen = 1'b1;
        end
        rdy8 = 1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_timeout: no done in 3000 cycles");
        end
        repeat (2) begin @(posedge clk); #1; end
        got.delete();
        for (int i = qb; i < q8.size(); i++) got.push_back(q8[i]);
        build_exp(8, 8, 0, 14);
        d = first_diff();
        checks++;
        if (got.size() != 64 || d != -1) begin
            errors++;
            $display("FAIL stall_seq: got %0d pairs diff@%0d want 64 diff@-1",
                     got.size(), d);
        end
        checks++;
        if (hold_err8 - hb != 0 || done_cnt8 - db != 1) begin
            errors++;
            $display("FAIL stall_hold: got hold_errs=%0d done=%0d want 0 1",
                     hold_err8 - hb, done_cnt8 - db);
        end
        checks++;
        if (stall_cnt8 - sb == 0) begin
            errors++;
            $display("FAIL stall_seen: got 0 stalled cycles want >0");
        end
    endtask

    task automatic test_reset_mid();
        int db;
        rdy8 = 1; start8 = 1; mode8 = 1;
        @(posedge clk); #1;
        start8 = 0; rdy8 = 0;
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if ({busy8, bus8.pair_valid} !== 2'b11) begin
            errors++;
            $display("FAIL mid_emit busy/valid: got %b want 11",
                     {busy8, bus8.pair_valid});
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({busy8, done8, err8, bus8.pair_valid, p8} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0",
                     {busy8, done8, err8, bus8.pair_valid, p8});
        end
        db = done_cnt8;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (done_cnt8 - db != 0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got done=%0d busy=%b want 0 0",
                     done_cnt8 - db, busy8);
        end
        rdy8 = 1;
        run_job(0, 0, 4'd7, 50);
        check_n7("post_reset_n7");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_n0();
        test_single_n7();
        test_limits();
        test_sweep();
        test_asym();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
